prod_accum_stage: RTL and testbench

//  - Downstream consumer of the 8x8 array multiplier's 16-bit product.
//  - Accumulates LEN consecutive products into one ACC_W-bit sum (dot-product / MAC frame).
//  - Presents each finished sum on a valid/ready output, with a sticky per-frame overflow flag.
//  - Upstream drives prod from the multiplier output, registered by its own operand/product stage.

---
 rtl/prod_accum_stage.sv | 116 +++++++++++
 tb/tb_prod_accum_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/prod_accum_stage.sv
// Sums LEN products into one frame result; out_valid rises the cycle after the LEN-th beat, and in_ready is low while a result waits.
// Overflow sets the sticky ovf flag. Define SATURATE_EN to clamp acc at all-ones; without it, acc wraps.
module prod_accum_stage #(
  parameter int LEN   = 8,
  parameter int ACC_W = 20,
  parameter int CNT_W = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [15:0]      prod,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt, acc_add;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_nxt, out_valid_nxt;
  logic [ACC_W:0]   sum;
  logic             accept;

  // Bit ACC_W of the widened sum is the carry out of the accumulator.
  assign sum = (ACC_W + 1)'(acc) + (ACC_W + 1)'(prod);

`ifdef SATURATE_EN
  assign acc_add = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_add = sum[ACC_W-1:0];
`endif

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    cnt_nxt       = cnt;
    ovf_nxt       = ovf;
    out_valid_nxt = out_valid;
    in_ready      = 1'b0;
    accept        = 1'b0;

    case (state)
      IDLE: begin
        in_ready = !rst;
        accept   = in_valid && in_ready;
        if (accept) begin
          acc_nxt = ACC_W'(prod);
          cnt_nxt = CNT_W'(1);
          ovf_nxt = 1'b0;
          if (LEN == 1) begin
            state_nxt     = DONE;
            out_valid_nxt = 1'b1;
          end else begin
            state_nxt = ACC;
          end
        end
      end
      ACC: begin
        in_ready = !rst;
        accept   = in_valid && in_ready;
        if (accept) begin
          acc_nxt = acc_add;
          cnt_nxt = cnt + 1'b1;
          if (sum[ACC_W]) ovf_nxt = 1'b1;
          if (cnt_nxt == LAST) begin
            state_nxt     = DONE;
            out_valid_nxt = 1'b1;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt     = IDLE;
          out_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Abort wins over any beat or handshake in the same cycle.
    if (clr) begin
      state_nxt     = IDLE;
      acc_nxt       = '0;
      cnt_nxt       = '0;
      ovf_nxt       = 1'b0;
      out_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      ovf       <= ovf_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  assign out_sum = acc;

endmodule

// File: tb/tb_prod_accum_stage.sv
// Directed bench: default instance (ACC_W=20) and a narrow instance (ACC_W=18) share stimulus.
module tb_prod_accum_stage;

`ifdef SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [15:0] prod = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, ovf;
  logic [19:0] out_sum;
  logic [3:0]  cnt;
  logic        in_ready18, out_valid18, ovf18;
  logic [17:0] out_sum18;
  logic [3:0]  cnt18;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prod_accum_stage #(.LEN(8), .ACC_W(20)) dut (
    .clk(clk), .rst(rst), .clr(clr), .prod(prod), .in_valid(in_valid),
    .in_ready(in_ready), .out_sum(out_sum), .out_valid(out_valid),
    .out_ready(out_ready), .ovf(ovf), .cnt(cnt)
  );

  prod_accum_stage #(.LEN(8), .ACC_W(18)) dut18 (
    .clk(clk), .rst(rst), .clr(clr), .prod(prod), .in_valid(in_valid),
    .in_ready(in_ready18), .out_sum(out_sum18), .out_valid(out_valid18),
    .out_ready(out_ready), .ovf(ovf18), .cnt(cnt18)
  );

  typedef struct {
    int base;
    int inc;
    bit gapped;
    int exp_sum;
    bit exp_ovf;
    int exp_sum18;
    bit exp_ovf18;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Sends 8 beats (base + k*inc), then checks the result and drains it.
  task automatic run_frame(input vec_t v, input int id);
    int early;
    int cnt_bad;
    early   = 0;
    cnt_bad = 0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      prod     = 16'(v.base + k * v.inc);
      @(negedge clk);
      in_valid = 1'b0;
      if (k < 7) begin
        if (out_valid || out_valid18) early++;
        if (cnt != 4'(k + 1)) cnt_bad++;
        if (v.gapped) begin
          for (int g = 0; g <= (k % 3); g++) begin
            @(negedge clk);
            if (out_valid || out_valid18) early++;
          end
        end
      end
    end
    chk($sformatf("f%0d_early_valid", id), early, 0);
    chk($sformatf("f%0d_cnt_progress", id), cnt_bad, 0);
    chk($sformatf("f%0d_out_valid", id), out_valid, 1);
    chk($sformatf("f%0d_out_sum", id), out_sum, v.exp_sum);
    chk($sformatf("f%0d_ovf", id), ovf, v.exp_ovf);
    chk($sformatf("f%0d_cnt", id), cnt, 8);
    chk($sformatf("f%0d_out_sum18", id), out_sum18, v.exp_sum18);
    chk($sformatf("f%0d_ovf18", id), ovf18, v.exp_ovf18);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk($sformatf("f%0d_drained", id), out_valid, 0);
    chk($sformatf("f%0d_ready_again", id), in_ready, 1);
  endtask

  task automatic send_beats(input int n, input int p);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      prod     = 16'(p);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  vec_t vecs[6];
  vec_t v;

  initial begin
    vecs[0] = '{65025, 0,   1'b0, 520200, 1'b0, SAT ? 262143 : 258056, 1'b1};
    vecs[1] = '{1,     1,   1'b1, 36,     1'b0, 36,                    1'b0};
    vecs[2] = '{65535, 0,   1'b1, 524280, 1'b0, SAT ? 262143 : 262136, 1'b1};
    vecs[3] = '{100,   100, 1'b0, 3600,   1'b0, 3600,                  1'b0};
    vecs[4] = '{0,     0,   1'b1, 0,      1'b0, 0,                     1'b0};
    vecs[5] = '{40000, 0,   1'b0, 320000, 1'b0, SAT ? 262143 : 57856,  1'b1};

    // Reset held for 3 cycles with a beat offered.
    in_valid = 1'b1;
    prod     = 16'd9;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_in_ready18", in_ready18, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_cnt", cnt, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_frame(vecs[i], i);

    // Backpressure: result held for 5 cycles while beats are offered.
    send_beats(8, 7);
    in_valid = 1'b1;
    prod     = 16'd7;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_valid_c%0d", c), out_valid, 1);
      chk($sformatf("bp_sum_c%0d", c), out_sum, 56);
      chk($sformatf("bp_in_ready_c%0d", c), in_ready, 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_drained", out_valid, 0);
    v = '{2, 0, 1'b0, 16, 1'b0, 16, 1'b0};
    run_frame(v, 10);

    // Abort via clr after 3 beats; the beat in the clr cycle is dropped.
    send_beats(3, 65025);
    chk("abort_cnt3", cnt, 3);
    clr      = 1'b1;
    in_valid = 1'b1;
    prod     = 16'd555;
    #1;
    chk("abort_in_ready_during_clr", in_ready, 1);
    @(negedge clk);
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("abort_cnt0", cnt, 0);
    chk("abort_sum0", out_sum, 0);
    chk("abort_valid0", out_valid, 0);
    v = '{1, 0, 1'b0, 8, 1'b0, 8, 1'b0};
    run_frame(v, 11);

    // Abort via asynchronous reset mid-frame.
    send_beats(3, 500);
    rst = 1'b1;
    #1;
    chk("midrst_cnt", cnt, 0);
    chk("midrst_sum", out_sum, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_no_spurious_valid", out_valid, 0);
    run_frame(v, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
